ram_port_arbiter: RTL and testbench

Shares one two-port synchronous RAM (`simple_dual_port_ram`-style: per-port `wr_en`/`rd_en`/`addr`/`wdata`, `rdata` valid the cycle after `rd_en`) among `NUM_REQ` requesters. Each cycle, up to two requests are granted, one to port A and one to port B. Grants are round-robin by default, with same-address hazard deferral. Read data is routed back to the issuing requester. The block sits between the client masters and the RAM instance and is the only driver of the RAM's port inputs.

---
 rtl/ram_port_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Two-port RAM arbiter: grants up to two requesters per cycle (A/B), registers RAM commands
// and routes read data back by tag. Define ARB_FIXED_PRIORITY_EN for fixed-priority grants.
module ram_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned NUM_REQ    = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               resp_valid,
  output logic [NUM_REQ*DATA_WIDTH-1:0]    resp_rdata,
  output logic                             wr_en_a,
  output logic                             rd_en_a,
  output logic [ADDR_WIDTH-1:0]            addr_a,
  output logic [DATA_WIDTH-1:0]            wdata_a,
  input  logic [DATA_WIDTH-1:0]            rdata_a,
  output logic                             wr_en_b,
  output logic                             rd_en_b,
  output logic [ADDR_WIDTH-1:0]            addr_b,
  output logic [DATA_WIDTH-1:0]            wdata_b,
  input  logic [DATA_WIDTH-1:0]            rdata_b
);

  localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IdW-1:0] LastId = IdW'(NUM_REQ - 1);

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  function automatic logic [IdW-1:0] next_id(input logic [IdW-1:0] id);
    return (id == LastId) ? '0 : id + 1'b1;
  endfunction

  // Grant scan
  logic [IdW-1:0] ptr_q, ptr_d;
  logic [IdW-1:0] scan_idx;
  logic [IdW-1:0] a_idx, b_idx;
  logic           a_found, b_found;
  logic           hazard, grant_a, grant_b;

  always_comb begin
    a_found  = 1'b0;
    b_found  = 1'b0;
    a_idx    = '0;
    b_idx    = '0;
    scan_idx = ptr_q;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (req_valid[scan_idx]) begin
        if (!a_found) begin
          a_found = 1'b1;
          a_idx   = scan_idx;
        end else if (!b_found) begin
          b_found = 1'b1;
          b_idx   = scan_idx;
        end
      end
      scan_idx = next_id(scan_idx);
    end
  end

  // A same-address pair with any write lets only A through; the B slot stays empty.
  assign hazard  = a_found && b_found && (addr_arr[a_idx] == addr_arr[b_idx]) &&
                   (req_we[a_idx] || req_we[b_idx]);
  assign grant_a = rst && a_found;
  assign grant_b = rst && b_found && !hazard;

  always_comb begin
    req_ready = '0;
    if (grant_a) req_ready[a_idx] = 1'b1;
    if (grant_b) req_ready[b_idx] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
`ifdef ARB_FIXED_PRIORITY_EN
    ptr_d = '0;
`else
    if (grant_b) begin
      ptr_d = next_id(b_idx);
    end else if (grant_a) begin
      ptr_d = next_id(a_idx);
    end
`endif
  end

  // Command stage
  logic                  wr_en_a_q, wr_en_a_d, rd_en_a_q, rd_en_a_d;
  logic                  wr_en_b_q, wr_en_b_d, rd_en_b_q, rd_en_b_d;
  logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [DATA_WIDTH-1:0] wdata_a_q, wdata_a_d, wdata_b_q, wdata_b_d;

  always_comb begin
    wr_en_a_d = grant_a && req_we[a_idx];
    rd_en_a_d = grant_a && !req_we[a_idx];
    addr_a_d  = grant_a ? addr_arr[a_idx]  : addr_a_q;
    wdata_a_d = grant_a ? wdata_arr[a_idx] : wdata_a_q;
    wr_en_b_d = grant_b && req_we[b_idx];
    rd_en_b_d = grant_b && !req_we[b_idx];
    addr_b_d  = grant_b ? addr_arr[b_idx]  : addr_b_q;
    wdata_b_d = grant_b ? wdata_arr[b_idx] : wdata_b_q;
  end

  assign wr_en_a = wr_en_a_q;
  assign rd_en_a = rd_en_a_q;
  assign addr_a  = addr_a_q;
  assign wdata_a = wdata_a_q;
  assign wr_en_b = wr_en_b_q;
  assign rd_en_b = rd_en_b_q;
  assign addr_b  = addr_b_q;
  assign wdata_b = wdata_b_q;

  // Tag pipeline: stage 1 sits alongside the command, stage 2 alongside RAM rdata.
  logic           rd1_a_q, rd1_a_d, rd2_a_q, rd2_a_d;
  logic           rd1_b_q, rd1_b_d, rd2_b_q, rd2_b_d;
  logic [IdW-1:0] id1_a_q, id1_a_d, id2_a_q, id2_a_d;
  logic [IdW-1:0] id1_b_q, id1_b_d, id2_b_q, id2_b_d;

  always_comb begin
    rd1_a_d = rd_en_a_d;
    id1_a_d = a_idx;
    rd1_b_d = rd_en_b_d;
    id1_b_d = b_idx;
    rd2_a_d = rd1_a_q;
    id2_a_d = id1_a_q;
    rd2_b_d = rd1_b_q;
    id2_b_d = id1_b_q;
  end

  // Response stage
  logic [NUM_REQ-1:0]    resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q [NUM_REQ];
  logic [DATA_WIDTH-1:0] resp_rdata_d [NUM_REQ];

  always_comb begin
    resp_valid_d = '0;
    resp_rdata_d = resp_rdata_q;
    if (rd2_a_q) begin
      resp_valid_d[id2_a_q] = 1'b1;
      resp_rdata_d[id2_a_q] = rdata_a;
    end
    if (rd2_b_q) begin
      resp_valid_d[id2_b_q] = 1'b1;
      resp_rdata_d[id2_b_q] = rdata_b;
    end
  end

  assign resp_valid = resp_valid_q;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_pack
    assign resp_rdata[i*DATA_WIDTH +: DATA_WIDTH] = resp_rdata_q[i];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q        <= '0;
      wr_en_a_q    <= 1'b0;
      rd_en_a_q    <= 1'b0;
      addr_a_q     <= '0;
      wdata_a_q    <= '0;
      wr_en_b_q    <= 1'b0;
      rd_en_b_q    <= 1'b0;
      addr_b_q     <= '0;
      wdata_b_q    <= '0;
      rd1_a_q      <= 1'b0;
      id1_a_q      <= '0;
      rd2_a_q      <= 1'b0;
      id2_a_q      <= '0;
      rd1_b_q      <= 1'b0;
      id1_b_q      <= '0;
      rd2_b_q      <= 1'b0;
      id2_b_q      <= '0;
      resp_valid_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) resp_rdata_q[i] <= '0;
    end else begin
      ptr_q        <= ptr_d;
      wr_en_a_q    <= wr_en_a_d;
      rd_en_a_q    <= rd_en_a_d;
      addr_a_q     <= addr_a_d;
      wdata_a_q    <= wdata_a_d;
      wr_en_b_q    <= wr_en_b_d;
      rd_en_b_q    <= rd_en_b_d;
      addr_b_q     <= addr_b_d;
      wdata_b_q    <= wdata_b_d;
      rd1_a_q      <= rd1_a_d;
      id1_a_q      <= id1_a_d;
      rd2_a_q      <= rd2_a_d;
      id2_a_q      <= id2_a_d;
      rd1_b_q      <= rd1_b_d;
      id1_b_q      <= id1_b_d;
      rd2_b_q      <= rd2_b_d;
      id2_b_q      <= id2_b_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed, table-driven bench for ram_port_arbiter with a behavioural dual-port RAM.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_we, req_ready, resp_valid;
  logic [15:0] req_addr;
  logic [31:0] req_wdata, resp_rdata;
  logic        wr_en_a, rd_en_a, wr_en_b, rd_en_b;
  logic [3:0]  addr_a, addr_b;
  logic [7:0]  wdata_a, wdata_b, rdata_a, rdata_b;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .NUM_REQ   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .wr_en_a   (wr_en_a),
    .rd_en_a   (rd_en_a),
    .addr_a    (addr_a),
    .wdata_a   (wdata_a),
    .rdata_a   (rdata_a),
    .wr_en_b   (wr_en_b),
    .rd_en_b   (rd_en_b),
    .addr_b    (addr_b),
    .wdata_b   (wdata_b),
    .rdata_b   (rdata_b)
  );

  // Behavioural RAM; mem[a] preloaded with {4'hC, a}.
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (wr_en_a) mem[addr_a] <= wdata_a;
    if (wr_en_b) mem[addr_b] <= wdata_b;
    if (rd_en_a) rdata_a <= mem[addr_a];
    if (rd_en_b) rdata_b <= mem[addr_b];
  end

  typedef struct {
    logic        rst_n;
    logic [3:0]  valid;
    logic [3:0]  we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  exp_ready;
    logic [3:0]  exp_rv;
    logic [31:0] exp_rdata;
    logic [31:0] mask;
  } vec_t;

  vec_t tbl [16];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [3:0] w,
                              input logic [15:0] a, input logic [31:0] d,
                              input logic [3:0] er, input logic [3:0] ev,
                              input logic [31:0] ed, input logic [31:0] m);
    vec_t t;
    t.rst_n = r; t.valid = v; t.we = w; t.addr = a; t.wdata = d;
    t.exp_ready = er; t.exp_rv = ev; t.exp_rdata = ed; t.mask = m;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] w,
                       input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    rst       = r;
    req_valid = v;
    req_we    = w;
    req_addr  = a;
    req_wdata = d;
    #1;
  endtask

  logic [3:0] exp_r;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = {4'hC, 4'(i)};
    rdata_a = '0;
    rdata_b = '0;
    rst = 1'b0; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;

    // Reset held with all valid, then release: first grants 0/1.
    for (int i = 0; i < 3; i++) tbl[i] = mk(0, 4'hF, 4'h0, 16'hBA98, 0, 4'h0, 4'h0, 0, 0);
    tbl[3]  = mk(1, 4'hF, 4'h0, 16'hBA98, 0, 4'h3, 4'h0, 0, 0);
    tbl[4]  = mk(1, 4'h0, 4'h0, 16'h0000, 0, 4'h0, 4'h0, 0, 0);
    // Dual write: req0 0xAA->3, req2 0x55->7; then read both back.
    tbl[5]  = mk(1, 4'h5, 4'h5, 16'h0703, 32'h0055_00AA, 4'h5, 4'h0, 0, 0);
    tbl[6]  = mk(1, 4'h5, 4'h0, 16'h0703, 0, 4'h5, 4'h3, 32'h0000_C9C8, 32'h0000_FFFF);
    tbl[7]  = mk(1, 4'h0, 4'h0, 16'h0000, 0, 4'h0, 4'h0, 32'h0000_C9C8, 32'h0000_FFFF);
    // Write-write hazard on addr 5: req1 first, req2 next cycle.
    tbl[8]  = mk(1, 4'h6, 4'h6, 16'h0550, 32'h0022_1100, 4'h2, 4'h0, 0, 0);
    tbl[9]  = mk(1, 4'h4, 4'h4, 16'h0500, 32'h0022_0000, 4'h4, 4'h5,
                 32'h0055_C9AA, 32'h00FF_FFFF);
    tbl[10] = mk(1, 4'h0, 4'h0, 16'h0000, 0, 4'h0, 4'h0, 0, 0);
    tbl[11] = mk(1, 4'h8, 4'h0, 16'h5000, 0, 4'h8, 4'h0, 0, 0);
    tbl[12] = mk(1, 4'h0, 4'h0, 16'h0000, 0, 4'h0, 4'h0, 0, 0);
    tbl[13] = mk(1, 4'h0, 4'h0, 16'h0000, 0, 4'h0, 4'h0, 0, 0);
    tbl[14] = mk(1, 4'h0, 4'h0, 16'h0000, 0, 4'h0, 4'h8, 32'h2255_C9AA, 32'hFFFF_FFFF);
    tbl[15] = mk(1, 4'h0, 4'h0, 16'h0000, 0, 4'h0, 4'h0, 32'h2255_C9AA, 32'hFFFF_FFFF);

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].rst_n, tbl[i].valid, tbl[i].we, tbl[i].addr, tbl[i].wdata);
      chk($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(tbl[i].exp_ready));
      chk($sformatf("v%0d resp_valid", i), 32'(resp_valid), 32'(tbl[i].exp_rv));
      if (tbl[i].mask != 0)
        chk($sformatf("v%0d resp_rdata", i), resp_rdata & tbl[i].mask,
            tbl[i].exp_rdata & tbl[i].mask);
      if (!tbl[i].rst_n) begin
        chk($sformatf("v%0d enables", i), 32'({wr_en_a, rd_en_a, wr_en_b, rd_en_b}), 32'h0);
        chk($sformatf("v%0d addr", i), 32'({addr_a, addr_b}), 32'h0);
      end
    end

    // Fairness: all four read continuously.
    for (int c = 0; c < 6; c++) begin
      drive(1, 4'hF, 4'h0, 16'hBA98, 0);
`ifdef ARB_FIXED_PRIORITY_EN
      exp_r = 4'b0011;
`else
      exp_r = (c % 2 == 0) ? 4'b0011 : 4'b1100;
`endif
      chk($sformatf("rr%0d req_ready", c), 32'(req_ready), 32'(exp_r));
    end
    for (int c = 0; c < 4; c++) drive(1, 4'h0, 4'h0, 16'h0000, 0);

    // Reset one cycle after accepting a read from req3: no response may appear.
    drive(1, 4'h8, 4'h0, 16'hB000, 0);
    chk("midrst accept", 32'(req_ready), 32'h8);
    drive(0, 4'h0, 4'h0, 16'h0000, 0);
    chk("midrst ready", 32'(req_ready), 32'h0);
    for (int c = 0; c < 5; c++) begin
      drive(1, 4'h0, 4'h0, 16'h0000, 0);
      chk($sformatf("midrst%0d resp_valid", c), 32'(resp_valid), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
